// File: rtl/perm_stream_ctrl.sv
// Sequencer for the permutation generator: reset it once, let it mix, snapshot the
// packed permutation, stream it element by element, repeat for the requested count.
module perm_stream_ctrl #(
    parameter int N_ELEM = 16,
    parameter int ELEM_W = 4,
    parameter int SETTLE = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 num_perms,
    output logic                       gen_rst,
    input  logic [N_ELEM*ELEM_W-1:0]   seq_all,
    output logic [ELEM_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       perm_err
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_GEN_RST | generator held in reset for one cycle
    // S_SETTLE  | generator free-runs for SETTLE cycles
    // S_CAPTURE | snapshot seq_all and run the duplicate check
    // S_STREAM  | hand out one element per handshake
    // S_DONE    | one-cycle done pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GEN_RST = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int SEQ_W = N_ELEM * ELEM_W;
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        rem_q, rem_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]  elem_idx_q, elem_idx_d;
    logic [SEQ_W-1:0]  snap_q, snap_d;

    logic              gen_rst_q, gen_rst_d;
    logic [ELEM_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              perm_err_q, perm_err_d;

    logic              dup_found;
    logic              xfer;
    logic [ELEM_W-1:0] snap_elems [N_ELEM];

    // Pairwise compare of every element against every later one.
    always_comb begin
        dup_found = 1'b0;
        for (int i = 0; i < N_ELEM; i++) begin
            for (int j = i + 1; j < N_ELEM; j++) begin
                if (seq_all[i*ELEM_W +: ELEM_W] == seq_all[j*ELEM_W +: ELEM_W]) begin
                    dup_found = 1'b1;
                end
            end
        end
    end

    assign xfer = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        settle_cnt_d = settle_cnt_q;
        elem_idx_d   = elem_idx_q;
        snap_d       = snap_q;
        perm_err_d   = perm_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d      = num_perms;
                    perm_err_d = 1'b0;
                    state_d    = (num_perms == 8'd0) ? S_DONE : S_GEN_RST;
                end
            end
            S_GEN_RST: begin
                settle_cnt_d = SETTLE_LOAD;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - CNT_ONE;
                end
            end
            S_CAPTURE: begin
                snap_d     = seq_all;
                elem_idx_d = '0;
                if (dup_found) begin
                    perm_err_d = 1'b1;
                end
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (xfer) begin
                    if (elem_idx_q == LAST_IDX) begin
                        rem_d      = rem_q - 8'd1;
                        elem_idx_d = '0;
                        if (rem_d == 8'd0) begin
                            state_d = S_DONE;
                        end else begin
                            // Later permutations keep the generator running; no second reset.
                            settle_cnt_d = SETTLE_LOAD;
                            state_d      = S_SETTLE;
                        end
                    end else begin
                        elem_idx_d = elem_idx_q + IDX_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_ELEM; i++) begin
            snap_elems[i] = snap_d[i*ELEM_W +: ELEM_W];
        end
    end

    // Outputs are registered copies of what the next state will present.
    always_comb begin
        gen_rst_d   = (state_d == S_GEN_RST);
        out_valid_d = (state_d == S_STREAM);
        out_last_d  = out_valid_d && (elem_idx_d == LAST_IDX);
        out_data_d  = out_valid_d ? snap_elems[elem_idx_d] : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            settle_cnt_q <= '0;
            elem_idx_q   <= '0;
            snap_q       <= '0;
            gen_rst_q    <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            perm_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            settle_cnt_q <= settle_cnt_d;
            elem_idx_q   <= elem_idx_d;
            snap_q       <= snap_d;
            gen_rst_q    <= gen_rst_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            perm_err_q   <= perm_err_d;
        end
    end

    assign gen_rst   = gen_rst_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign perm_err  = perm_err_q;

endmodule

// File: tb/tb_perm_stream_ctrl.sv
// Bench for perm_stream_ctrl: table of runs with a stub or a swap-mixing generator model,
// scoreboarded element stream, plus a reset-mid-stream sequence.
module tb_perm_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, gen_rst, out_valid, out_ready, out_last, busy, done, perm_err;
    logic [7:0]  num_perms;
    logic [63:0] seq_all;
    logic [3:0]  out_data;

    always #5 clk = ~clk;

    perm_stream_ctrl #(.N_ELEM(16), .ELEM_W(4), .SETTLE(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_perms(num_perms), .gen_rst(gen_rst),
        .seq_all(seq_all), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .perm_err(perm_err)
    );

    // Generator model: identity on gen_rst, then an LFSR-chosen swap each cycle.
    logic [3:0]  gen_e [16];
    logic [15:0] lfsr;
    logic [3:0]  ga, gb;
    logic [63:0] gen_packed, stub_val;
    logic        use_gen;

    assign ga = lfsr[3:0];
    assign gb = lfsr[7:4];

    always @(posedge clk) begin
        if (gen_rst) begin
            for (int i = 0; i < 16; i++) gen_e[i] <= 4'(i);
            lfsr <= 16'hACE1;
        end else begin
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            gen_e[ga] <= gen_e[gb];
            gen_e[gb] <= gen_e[ga];
        end
    end

    always_comb begin
        gen_packed = '0;
        for (int i = 0; i < 16; i++) gen_packed[i*4 +: 4] = gen_e[i];
    end

    assign seq_all = use_gen ? gen_packed : stub_val;

    typedef struct packed {
        logic [3:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0]  num;
        logic [63:0] stub;
        logic        gen;
        logic        toggle;
        int          first_valid;
        int          last_cyc;
        int          done_cyc;
        int          xfers;
        int          lasts;
        int          genrst;
        int          busy_cnt;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    int n_tests = 0;
    int n_fail  = 0;

    int st_first_valid, st_last_cyc, st_done_cyc, st_xfers, st_lasts;
    int st_genrst, st_genrst_first, st_busy, st_done_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] num, input logic [63:0] stub, input logic gen,
                                input logic toggle, input int fv, input int lc, input int dc,
                                input int xf, input int ls, input int gr, input int bc,
                                input logic err);
        vec_t v;
        v.num = num; v.stub = stub; v.gen = gen; v.toggle = toggle;
        v.first_valid = fv; v.last_cyc = lc; v.done_cyc = dc; v.xfers = xf;
        v.lasts = ls; v.genrst = gr; v.busy_cnt = bc; v.err = err;
        return v;
    endfunction

    // Drives one start and follows the run cycle by cycle (cycle n = after edge n-1).
    task automatic run_vec(input vec_t v, input int id);
        logic        prev_valid, prev_stall, prev_last, done_seen;
        logic [3:0]  prev_data;
        logic [15:0] mask;
        logic [63:0] hist [0:199];
        exp_t        e;

        st_first_valid = -1; st_last_cyc = -1; st_done_cyc = -1; st_xfers = 0;
        st_lasts = 0; st_genrst = 0; st_genrst_first = -1; st_busy = 0; st_done_cnt = 0;
        exp_q.delete();
        use_gen  = v.gen;
        stub_val = v.stub;

        @(posedge clk); #1;
        start = 1'b1; num_perms = v.num; out_ready = 1'b1;
        if (!v.gen) begin
            for (int p = 0; p < int'(v.num); p++) begin
                for (int k = 0; k < 16; k++) begin
                    e.data = v.stub[k*4 +: 4];
                    e.last = (k == 15);
                    exp_q.push_back(e);
                end
            end
        end

        prev_valid = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        mask = '0; done_seen = 1'b0;
        for (int rel = 1; rel <= 150; rel++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = v.toggle ? (rel % 2 == 1) : 1'b1;
            @(negedge clk);
            hist[rel] = seq_all;
            if (rel == 1) check($sformatf("v%0d_perm_err_cleared", id), perm_err, 0);
            if (gen_rst) begin
                st_genrst++;
                if (st_genrst_first < 0) st_genrst_first = rel;
            end
            if (busy) st_busy++;
            if (done) begin
                st_done_cnt++;
                st_done_cyc = rel;
                done_seen = 1'b1;
            end
            if (out_valid) begin
                if (st_first_valid < 0) st_first_valid = rel;
                if (!prev_valid) begin
                    check($sformatf("v%0d_perm_err_c%0d", id, rel), perm_err, v.err);
                    if (v.gen) begin
                        for (int k = 0; k < 16; k++) begin
                            e.data = hist[rel-1][k*4 +: 4];
                            e.last = (k == 15);
                            exp_q.push_back(e);
                        end
                    end
                end
                if (prev_stall) begin
                    check($sformatf("v%0d_hold_data_c%0d", id, rel), out_data, prev_data);
                    check($sformatf("v%0d_hold_last_c%0d", id, rel), out_last, prev_last);
                end
                if (out_ready) begin
                    st_xfers++;
                    if (out_last) begin
                        st_lasts++;
                        st_last_cyc = rel;
                    end
                    check($sformatf("v%0d_sb_has_entry_c%0d", id, rel), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("v%0d_data_c%0d", id, rel), out_data, e.data);
                        check($sformatf("v%0d_last_c%0d", id, rel), out_last, e.last);
                    end
                    mask = mask | (16'd1 << out_data);
                    if (out_last) begin
                        if (v.gen) check($sformatf("v%0d_perm_complete_c%0d", id, rel), mask, 16'hFFFF);
                        mask = '0;
                    end
                end
            end
            prev_valid = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done_seen && !busy) break;
        end
        check($sformatf("v%0d_sb_drained", id), exp_q.size(), 0);
    endtask

    task automatic apply_and_check(input vec_t v, input int id);
        run_vec(v, id);
        check($sformatf("v%0d_first_valid_cycle", id), st_first_valid, v.first_valid);
        check($sformatf("v%0d_last_xfer_cycle", id), st_last_cyc, v.last_cyc);
        check($sformatf("v%0d_done_cycle", id), st_done_cyc, v.done_cyc);
        check($sformatf("v%0d_done_count", id), st_done_cnt, 1);
        check($sformatf("v%0d_transfers", id), st_xfers, v.xfers);
        check($sformatf("v%0d_last_pulses", id), st_lasts, v.lasts);
        check($sformatf("v%0d_gen_rst_count", id), st_genrst, v.genrst);
        check($sformatf("v%0d_gen_rst_first", id), st_genrst_first, (v.genrst > 0) ? 1 : -1);
        check($sformatf("v%0d_busy_cycles", id), st_busy, v.busy_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_cnt, busy_cnt;
        //            num   stub                    gen  tog  fv  lc   dc   xf  ls  gr  busy err
        vecs[0] = mk(8'd1, 64'hFEDCBA9876543210, 1'b0, 1'b0, 19, 34,  35, 16, 1, 1, 35,  1'b0);
        vecs[1] = mk(8'd1, 64'hFEDCBA9876543210, 1'b0, 1'b1, 19, 49,  50, 16, 1, 1, 50,  1'b0);
        vecs[2] = mk(8'd1, 64'h0000000000000000, 1'b0, 1'b0, 19, 34,  35, 16, 1, 1, 35,  1'b1);
        vecs[3] = mk(8'd1, 64'h0123456789ABCDEF, 1'b0, 1'b0, 19, 34,  35, 16, 1, 1, 35,  1'b0);
        vecs[4] = mk(8'd0, 64'hFEDCBA9876543210, 1'b0, 1'b0, -1, -1,  1,  0,  0, 0, 1,   1'b0);
        vecs[5] = mk(8'd3, 64'h0000000000000000, 1'b1, 1'b0, 19, 100, 101, 48, 3, 1, 101, 1'b0);

        rst = 1'b1; start = 1'b0; num_perms = '0; out_ready = 1'b0;
        use_gen = 1'b0; stub_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_gen_rst", gen_rst, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_last", out_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_perm_err", perm_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) apply_and_check(vecs[i], i);

        // Reset while element 7 is on the output, then a clean rerun.
        exp_q.delete();
        use_gen = 1'b0; stub_val = 64'hFEDCBA9876543210;
        @(posedge clk); #1;
        start = 1'b1; num_perms = 8'd1; out_ready = 1'b1;
        for (int rel = 1; rel <= 25; rel++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_elem7_data", out_data, 7);
        check("mid_elem7_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", out_valid, 0);
        check("after_rst_data", out_data, 0);
        check("after_rst_last", out_last, 0);
        check("after_rst_busy", busy, 0);
        check("after_rst_done", done, 0);
        check("after_rst_gen_rst", gen_rst, 0);
        done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("after_rst_no_done", done_cnt, 0);
        check("after_rst_idle", busy_cnt, 0);
        apply_and_check(vecs[0], 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
